// File: rtl/video_pkg.sv
// video_pkg: default 640x480@60 timing, TMDS control codes and timing type
package video_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
  typedef struct packed {
    logic [11:0] active;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] bp;
  } timing_t;
  function automatic logic [11:0] timing_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/sig_delay.sv
// sig_delay: resettable WIDTH-bit shift register of DEPTH stages, DEPTH=0 passes through
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    // shift one stage per clock, every stage cleared on reset
    always_ff @(posedge clk)
      if (rst) sr <= '{default: '0};
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, pixel request and delayed sync/de for TMDS
module video_timing_gen import video_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int H_POL = 0,
  parameter int V_POL = 0,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        req,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [1:0]  ctrl
);
  localparam timing_t HTIM = '{12'(H_ACTIVE), 12'(H_FP), 12'(H_SYNC), 12'(H_BP)};
  localparam timing_t VTIM = '{12'(V_ACTIVE), 12'(V_FP), 12'(V_SYNC), 12'(V_BP)};
  localparam logic [11:0] HT = timing_total(HTIM);
  localparam logic [11:0] VT = timing_total(VTIM);
  localparam logic [11:0] HS0 = HTIM.active + HTIM.fp;
  localparam logic [11:0] HS1 = HS0 + HTIM.sync;
  localparam logic [11:0] VS0 = VTIM.active + VTIM.fp;
  localparam logic [11:0] VS1 = VS0 + VTIM.sync;
  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);
  logic [11:0] h_cnt, v_cnt;
  logic h_last, v_last, de_raw, hs_raw, vs_raw, at_origin;
  logic [3:0] dly;
  assign h_last = h_cnt == HT - 12'd1;
  assign v_last = v_cnt == VT - 12'd1;
  assign de_raw = en && h_cnt < HTIM.active && v_cnt < VTIM.active;
  assign hs_raw = en && h_cnt >= HS0 && h_cnt < HS1;
  assign vs_raw = en && v_cnt >= VS0 && v_cnt < VS1;
  assign at_origin = h_cnt == '0;
  // raster position advances only while enabled
  always_ff @(posedge clk)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_last ? '0 : h_cnt + 12'd1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 12'd1;
    end
  // pixel request side, one clock behind the counters
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      y <= '0;
      req <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x <= h_cnt;
      y <= v_cnt;
      req <= de_raw;
      line_start <= en && at_origin;
      frame_start <= en && at_origin && v_cnt == '0;
    end
  sig_delay #(.WIDTH(4), .DEPTH(1 + PIPE_DLY)) u_dly (
    .clk(clk),
    .rst(rst),
    .d({vs_raw, hs_raw, de_raw, ~de_raw}),
    .q(dly)
  );
  assign de = dly[1];
  assign hsync = dly[2] ~^ HP;
  assign vsync = dly[3] ~^ VP;
  assign ctrl = dly[0] ? dly[3:2] : 2'b00;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: random and directed stimulus against a raster-position model
module tb_video_timing_gen;
  localparam int HA = 40, HF = 4, HS = 8, HB = 8;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NC = 8000;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [11:0] x0, y0, x1, y1;
  logic req0, ls0, fs0, hs0, vs0, de0, req1, ls1, fs1, hs1, vs1, de1;
  logic [1:0] ctrl0, ctrl1;
  int checks = 0, errors = 0;
  int k = 0, mp = 0;
  logic [2:0] hist [NC];
  int last_ls = -1, last_fs = -1, ls_per = 0, fs_per = 0, n_fs = 0;
  int first_req = -1, first_de0 = -1, first_de1 = -1;
  bit win_on = 0;
  int win_de = 0, win_hs = 0, win_vs = 0, win_c11 = 0;

  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(0), .PIPE_DLY(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .x(x0), .y(y0), .req(req0),
    .line_start(ls0), .frame_start(fs0), .hsync(hs0), .vsync(vs0),
    .de(de0), .ctrl(ctrl0));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1), .V_POL(1), .PIPE_DLY(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x1), .y(y1), .req(req1),
    .line_start(ls1), .frame_start(fs1), .hsync(hs1), .vsync(vs1),
    .de(de1), .ctrl(ctrl1));

  task automatic chk(input string n, input logic [11:0] a, input logic [11:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d expected %0d", n, k, a, e);
    end
  endtask

  task automatic step(input bit r, input bit e);
    int h, v;
    logic [2:0] rw, e0, e1;
    logic [11:0] ex, ey;
    logic er, el, ef;
    if (k >= NC) begin
      $display("FAIL step_budget: got %0d steps, limit %0d", k, NC);
      $fatal(1);
    end
    h = mp % HT;
    v = mp / HT;
    rw = r ? 3'b000 : {e && v >= VA + VF && v < VA + VF + VS,
                       e && h >= HA + HF && h < HA + HF + HS,
                       e && h < HA && v < VA};
    hist[k] = rw;
    if (r) for (int j = 1; j <= 2; j++) if (k - j >= 0) hist[k-j] = 3'b000;
    e0 = k >= 2 ? hist[k-2] : 3'b000;
    e1 = hist[k];
    ex = r ? 12'd0 : 12'(h);
    ey = r ? 12'd0 : 12'(v);
    er = !r && rw[0];
    el = !r && e && h == 0;
    ef = !r && e && mp == 0;
    rst = r;
    en = e;
    @(posedge clk);
    @(negedge clk);
    chk("x0", x0, ex); chk("y0", y0, ey); chk("req0", req0, er);
    chk("line_start0", ls0, el); chk("frame_start0", fs0, ef);
    chk("x1", x1, ex); chk("y1", y1, ey); chk("req1", req1, er);
    chk("line_start1", ls1, el); chk("frame_start1", fs1, ef);
    chk("hsync0", hs0, !e0[1]); chk("vsync0", vs0, !e0[2]);
    chk("de0", de0, e0[0]); chk("ctrl0", ctrl0, {e0[2], e0[1]});
    chk("hsync1", hs1, e1[1]); chk("vsync1", vs1, e1[2]);
    chk("de1", de1, e1[0]); chk("ctrl1", ctrl1, {e1[2], e1[1]});
    mp = r ? 0 : e ? (mp + 1) % FT : mp;
    if (ls0) begin
      if (last_ls >= 0) ls_per = k - last_ls;
      last_ls = k;
    end
    if (fs0) begin
      if (last_fs >= 0) fs_per = k - last_fs;
      last_fs = k;
      n_fs++;
    end
    if (req0 && first_req < 0) first_req = k;
    if (de0 && first_de0 < 0) first_de0 = k;
    if (de1 && first_de1 < 0) first_de1 = k;
    if (win_on) begin
      win_de += int'(de0);
      win_hs += int'(!hs0);
      win_vs += int'(!vs0);
      win_c11 += int'(ctrl1 == 2'b11);
    end
    k++;
  endtask

  initial begin
    int g, n;
    @(negedge clk);
    repeat (3) step(1, 0);
    step(0, 1);
    chk("first_fs", fs0, 1); chk("first_x", x0, 0);
    chk("first_y", y0, 0); chk("first_req", req0, 1);
    repeat (100) step(0, 1);
    win_on = 1;
    repeat (FT) step(0, 1);
    win_on = 0;
    chk("de_lag_pipe2", 12'(first_de0 - first_req), 2);
    chk("de_lag_pipe0", 12'(first_de1 - first_req), 0);
    chk("line_period", 12'(ls_per), 60);
    chk("frame_period", 12'(fs_per), 660);
    chk("de_per_frame", 12'(win_de), 240);
    chk("hsync_low_per_frame", 12'(win_hs), 88);
    chk("vsync_low_per_frame", 12'(win_vs), 120);
    chk("ctrl11_per_frame", 12'(win_c11), 16);
    g = 0;
    while (mp != 2 * HT + 20 && g < 2000) begin
      step(0, 1);
      g++;
    end
    chk("reach_pause_point", 12'(mp), 12'(2 * HT + 20));
    repeat (50) step(0, 0);
    chk("pause_x_hold", x0, 20);
    chk("pause_de_off", de0, 0);
    step(0, 1);
    step(0, 1);
    chk("resume_x", x0, 21);
    n = n_fs;
    g = 0;
    while (n_fs == n && g < 2000) begin
      step(0, 1);
      g++;
    end
    chk("stretched_frame_period", 12'(fs_per), 710);
    g = 0;
    while (mp != 3 * HT + 30 && g < 2000) begin
      step(0, 1);
      g++;
    end
    chk("reach_reset_point", 12'(mp), 12'(3 * HT + 30));
    step(1, 1);
    chk("rst_x", x0, 0); chk("rst_y", y0, 0);
    chk("rst_hsync", hs0, 1); chk("rst_de", de0, 0);
    step(0, 1);
    chk("restart_fs", fs0, 1); chk("restart_x", x0, 0); chk("restart_y", y0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
